// File: rtl/prbs9_ber_checker_pkg.sv
// Shared PRBS9 constants and checker state type for the receive-path BER checker
// and the transmit-side generator.
package prbs9_ber_checker_pkg;

    localparam int unsigned PRBS_LEN    = 9;
    localparam int unsigned PRBS_TAP_HI = 8;
    localparam int unsigned PRBS_TAP_LO = 4;
    localparam logic [PRBS_LEN-1:0] PRBS_SEED = 9'b110101010;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Next PRBS9 bit (x^9 + x^5 + 1) from a register holding the newest bit in s[0].
    function automatic logic prbs9_pred(input logic [PRBS_LEN-1:0] s);
        return s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO];
    endfunction

endpackage

// File: rtl/prbs9_ber_checker_if.sv
// Bit-stream and readout bundle of the PRBS9 BER checker; the checker uses the slave modport.
interface prbs9_ber_checker_if #(
    parameter int unsigned CNT_W = 64
);
    logic             i_valid;
    logic             i_bit;
    logic             i_clear;
    logic             i_relock;
    logic             o_lock;
    logic             o_err;
    logic [CNT_W-1:0] o_bit_cnt;
    logic [CNT_W-1:0] o_err_cnt;

    modport master (
        output i_valid, i_bit, i_clear, i_relock,
        input  o_lock, o_err, o_bit_cnt, o_err_cnt
    );

    modport slave (
        input  i_valid, i_bit, i_clear, i_relock,
        output o_lock, o_err, o_bit_cnt, o_err_cnt
    );
endinterface

// File: rtl/prbs9_ber_checker_lfsr.sv
// PRBS9 shift register: loads either an external bit or its own feedback, exposes the
// predicted next bit. Shared with the transmit-side generator.
module prbs9_lfsr
    import prbs9_ber_checker_pkg::*;
#(
    parameter logic [PRBS_LEN-1:0] SEED = PRBS_SEED
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    input  logic                i_sel_fb,
    input  logic                i_bit,
    output logic                o_pred,
    output logic [PRBS_LEN-1:0] o_state
);

    logic [PRBS_LEN-1:0] r_s;
    logic                w_pred;
    logic                w_in;

    assign w_pred  = prbs9_pred(r_s);
    assign w_in    = i_sel_fb ? w_pred : i_bit;
    assign o_pred  = w_pred;
    assign o_state = r_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s <= SEED;
        end else if (i_en) begin
            r_s <= {r_s[PRBS_LEN-2:0], w_in};
        end
    end

endmodule

// File: rtl/prbs9_ber_checker.sv
// Self-synchronising PRBS9 bit-error-rate checker with saturating bit/error counters.
// Optional LOCK_LOSS_EN macro adds windowed loss-of-lock detection.
module prbs9_ber_checker
    import prbs9_ber_checker_pkg::*;
#(
    parameter int unsigned CNT_W        = 64,
    parameter int unsigned LOCK_CNT     = 32
`ifdef LOCK_LOSS_EN
    ,
    parameter int unsigned LOCK_WIN     = 128,
    parameter int unsigned LOCK_ERR_MAX = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    prbs9_ber_checker_if.slave   bus
);

    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_load_cnt;
    logic [3:0]          w_load_nxt;
    logic [MATCH_W-1:0]  r_match_cnt;
    logic [MATCH_W-1:0]  w_match_nxt;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [CNT_W-1:0]    r_err_cnt;
    logic                r_lock;
    logic                r_err;
    logic                w_pred;
    logic [PRBS_LEN-1:0] w_s;
    logic                w_mis;
    logic                w_count;
    logic                w_win_lose;

    // Once locked the register free-runs on its own feedback, so line errors never corrupt it.
    prbs9_lfsr #(
        .SEED('0)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .i_en     (bus.i_valid),
        .i_sel_fb (r_state == ST_LOCKED),
        .i_bit    (bus.i_bit),
        .o_pred   (w_pred),
        .o_state  (w_s)
    );

    assign w_mis   = bus.i_bit ^ w_pred;
    assign w_count = bus.i_valid && (r_state == ST_LOCKED);

`ifdef LOCK_LOSS_EN
    localparam int unsigned WIN_W = $clog2(LOCK_WIN + 1);

    logic [WIN_W-1:0] r_win_cnt;
    logic [WIN_W-1:0] r_win_err;
    logic [WIN_W-1:0] w_win_err_inc;
    logic             w_win_end;

    always_comb begin
        w_win_err_inc = r_win_err + WIN_W'(w_mis);
        w_win_end     = (r_win_cnt == WIN_W'(LOCK_WIN - 1));
        w_win_lose    = w_win_end && (w_win_err_inc > WIN_W'(LOCK_ERR_MAX));
    end

    // Holding the window at zero outside ST_LOCKED gives a fresh window on every lock entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_cnt <= '0;
            r_win_err <= '0;
        end else if (r_state != ST_LOCKED) begin
            r_win_cnt <= '0;
            r_win_err <= '0;
        end else if (bus.i_valid) begin
            if (w_win_end) begin
                r_win_cnt <= '0;
                r_win_err <= '0;
            end else begin
                r_win_cnt <= r_win_cnt + 1'b1;
                r_win_err <= w_win_err_inc;
            end
        end
    end
`else
    assign w_win_lose = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_load_nxt  = r_load_cnt;
        w_match_nxt = r_match_cnt;
        if (bus.i_valid) begin
            case (r_state)
                ST_LOAD: begin
                    if (r_load_cnt == 4'(PRBS_LEN - 1)) begin
                        w_state_nxt = ST_VERIFY;
                        w_load_nxt  = '0;
                        w_match_nxt = '0;
                    end else begin
                        w_load_nxt = r_load_cnt + 1'b1;
                    end
                end
                ST_VERIFY: begin
                    if ((w_s == '0) || w_mis) begin
                        w_state_nxt = ST_LOAD;
                        w_load_nxt  = '0;
                    end else if (r_match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                        w_state_nxt = ST_LOCKED;
                        w_match_nxt = '0;
                    end else begin
                        w_match_nxt = r_match_cnt + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (w_win_lose) begin
                        w_state_nxt = ST_LOAD;
                        w_load_nxt  = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_LOAD;
                    w_load_nxt  = '0;
                end
            endcase
        end
        if (bus.i_relock) begin
            w_state_nxt = ST_LOAD;
            w_load_nxt  = '0;
            w_match_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_LOAD;
            r_load_cnt  <= '0;
            r_match_cnt <= '0;
            r_lock      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_load_cnt  <= w_load_nxt;
            r_match_cnt <= w_match_nxt;
            r_lock      <= (w_state_nxt == ST_LOCKED);
            r_err       <= w_count && w_mis;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_err_cnt <= '0;
        end else if (bus.i_clear) begin
            r_bit_cnt <= '0;
            r_err_cnt <= '0;
        end else if (w_count) begin
            if (r_bit_cnt != '1) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_mis && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign bus.o_lock    = r_lock;
    assign bus.o_err     = r_err;
    assign bus.o_bit_cnt = r_bit_cnt;
    assign bus.o_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_prbs9_ber_checker.sv
// Bench for prbs9_ber_checker: phase table plus a queue-based stream model; a second,
// narrow-counter instance shares the stimulus to exercise saturation.
module tb_prbs9_ber_checker;

    localparam int unsigned SMALL_W = 4;
    localparam longint unsigned SMALL_MAX = (64'd1 << SMALL_W) - 1;
    localparam int LOCK_BITS = 9 + 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prbs9_ber_checker_if #(.CNT_W(64))      bus ();
    prbs9_ber_checker_if #(.CNT_W(SMALL_W)) bus_s ();

    assign bus_s.i_valid  = bus.i_valid;
    assign bus_s.i_bit    = bus.i_bit;
    assign bus_s.i_clear  = bus.i_clear;
    assign bus_s.i_relock = bus.i_relock;

    prbs9_ber_checker #(.CNT_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    prbs9_ber_checker #(.CNT_W(SMALL_W)) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (bus_s.slave)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transmitted PRBS9 stream: seed MSB first, then b[n] = b[n-9] ^ b[n-5].
    bit tx[$];
    function automatic bit gen_next();
        logic [8:0] seed;
        bit b;
        seed = 9'b110101010;
        if (tx.size() < 9) b = seed[8 - tx.size()];
        else               b = tx[tx.size() - 9] ^ tx[tx.size() - 5];
        tx.push_back(b);
        return b;
    endfunction

    // Reference model: hist holds the last 9 reference bits, oldest first.
    bit              hist[$];
    int              m_good;
    bit              m_locked;
    bit              m_err;
    longint unsigned m_bits;
    longint unsigned m_errs;
    int              m_wbits;
    int              m_werrs;

    task automatic hist_push(input bit x);
        hist.push_back(x);
        if (hist.size() > 9) void'(hist.pop_front());
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 9; i++) hist.push_back(1'b0);
        m_good = 0; m_locked = 0; m_err = 0;
        m_bits = 0; m_errs = 0; m_wbits = 0; m_werrs = 0;
    endtask

    task automatic model_step(input bit b);
        bit p;
        bit zero;
        p = hist[0] ^ hist[4];
        m_err = 0;
        if (m_locked) begin
            hist_push(p);
            m_bits++;
            if (b != p) begin m_errs++; m_err = 1; end
`ifdef LOCK_LOSS_EN
            m_wbits++;
            if (b != p) m_werrs++;
            if (m_wbits == 128) begin
                if (m_werrs > 16) begin m_locked = 0; m_good = 0; end
                m_wbits = 0; m_werrs = 0;
            end
`endif
        end else if (m_good < 9) begin
            hist_push(b);
            m_good++;
        end else begin
            zero = 1;
            foreach (hist[i]) if (hist[i]) zero = 0;
            hist_push(b);
            if (zero || (b != p)) m_good = 0;
            else begin
                m_good++;
                if (m_good == LOCK_BITS) begin m_locked = 1; m_wbits = 0; m_werrs = 0; end
            end
        end
    endtask

    function automatic longint unsigned sat_small(input longint unsigned v);
        return (v > SMALL_MAX) ? SMALL_MAX : v;
    endfunction

    task automatic check_all(input bit exp_err);
        chk("lock",          bus.o_lock,      m_locked);
        chk("err_pulse",     bus.o_err,       exp_err);
        chk("bit_cnt",       bus.o_bit_cnt,   m_bits);
        chk("err_cnt",       bus.o_err_cnt,   m_errs);
        chk("small_bit_cnt", bus_s.o_bit_cnt, sat_small(m_bits));
        chk("small_err_cnt", bus_s.o_err_cnt, sat_small(m_errs));
    endtask

    // One valid bit followed by three idle cycles (symbol-rate enable every 4th clock).
    task automatic send(input bit b, input bit clr);
        bus.i_valid = 1'b1;
        bus.i_bit   = b;
        bus.i_clear = clr;
        @(posedge clk);
        model_step(b);
        if (clr) begin m_bits = 0; m_errs = 0; end
        #1;
        bus.i_valid = 1'b0;
        bus.i_clear = 1'b0;
        check_all(m_err);
        repeat (3) begin
            @(posedge clk);
            #1;
            check_all(1'b0);
        end
    endtask

    task automatic ctrl(input bit clr, input bit rel);
        bus.i_clear  = clr;
        bus.i_relock = rel;
        @(posedge clk);
        if (clr) begin m_bits = 0; m_errs = 0; end
        if (rel) begin m_locked = 0; m_good = 0; end
        #1;
        bus.i_clear  = 1'b0;
        bus.i_relock = 1'b0;
        check_all(1'b0);
    endtask

    typedef enum int {OP_PRBS, OP_FLIP, OP_ZERO, OP_RAND, OP_CLEAR, OP_RELOCK, OP_BOTH, OP_CLRBIT} op_e;
    typedef struct {
        op_e             op;
        int              n;
        bit              exp_lock;
        bit              chk_cnt;
        longint unsigned exp_bits;
        longint unsigned exp_errs;
    } vec_t;

    vec_t tbl[$];

    initial begin
        tbl.push_back('{OP_PRBS,    40, 1'b0, 1'b1,    0, 0});
        tbl.push_back('{OP_PRBS,     1, 1'b1, 1'b1,    0, 0});
        tbl.push_back('{OP_PRBS,  1000, 1'b1, 1'b1, 1000, 0});
        tbl.push_back('{OP_PRBS,    99, 1'b1, 1'b1, 1099, 0});
        tbl.push_back('{OP_FLIP,     2, 1'b1, 1'b1, 1101, 2});
        tbl.push_back('{OP_PRBS,    50, 1'b1, 1'b1, 1151, 2});
        tbl.push_back('{OP_CLEAR,    1, 1'b1, 1'b1,    0, 0});
        tbl.push_back('{OP_PRBS,    10, 1'b1, 1'b1,   10, 0});
        tbl.push_back('{OP_CLRBIT,   1, 1'b1, 1'b1,    0, 0});
        tbl.push_back('{OP_PRBS,     5, 1'b1, 1'b1,    5, 0});
        tbl.push_back('{OP_RELOCK,   1, 1'b0, 1'b1,    5, 0});
        tbl.push_back('{OP_PRBS,    40, 1'b0, 1'b1,    5, 0});
        tbl.push_back('{OP_PRBS,     1, 1'b1, 1'b1,    5, 0});
        tbl.push_back('{OP_BOTH,     1, 1'b0, 1'b1,    0, 0});
        tbl.push_back('{OP_ZERO,   500, 1'b0, 1'b1,    0, 0});
        tbl.push_back('{OP_RELOCK,   1, 1'b0, 1'b1,    0, 0});
        tbl.push_back('{OP_PRBS,    41, 1'b1, 1'b1,    0, 0});
        tbl.push_back('{OP_PRBS,    20, 1'b1, 1'b1,   20, 0});
        tbl.push_back('{OP_RELOCK,   1, 1'b0, 1'b1,   20, 0});
        tbl.push_back('{OP_PRBS,    11, 1'b0, 1'b1,   20, 0});
        tbl.push_back('{OP_FLIP,     1, 1'b0, 1'b1,   20, 0});
        tbl.push_back('{OP_PRBS,    40, 1'b0, 1'b1,   20, 0});
        tbl.push_back('{OP_PRBS,     1, 1'b1, 1'b1,   20, 0});
        tbl.push_back('{OP_PRBS,    30, 1'b1, 1'b1,   50, 0});
`ifdef LOCK_LOSS_EN
        tbl.push_back('{OP_RAND,   300, 1'b0, 1'b0,    0, 0});
`else
        tbl.push_back('{OP_RAND,   300, 1'b1, 1'b0,    0, 0});
`endif
        tbl.push_back('{OP_RELOCK,   1, 1'b0, 1'b0,    0, 0});
        tbl.push_back('{OP_PRBS,    41, 1'b1, 1'b0,    0, 0});

        bus.i_valid  = 1'b0;
        bus.i_bit    = 1'b0;
        bus.i_clear  = 1'b0;
        bus.i_relock = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all(1'b0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check_all(1'b0);

        foreach (tbl[k]) begin
            case (tbl[k].op)
                OP_PRBS:   for (int i = 0; i < tbl[k].n; i++) send(gen_next(), 1'b0);
                OP_FLIP:   for (int i = 0; i < tbl[k].n; i++) send(~gen_next(), 1'b0);
                OP_ZERO:   for (int i = 0; i < tbl[k].n; i++) send(1'b0, 1'b0);
                OP_RAND:   for (int i = 0; i < tbl[k].n; i++) send(1'($urandom_range(0, 1)), 1'b0);
                OP_CLRBIT: send(gen_next(), 1'b1);
                OP_CLEAR:  ctrl(1'b1, 1'b0);
                OP_RELOCK: ctrl(1'b0, 1'b1);
                OP_BOTH:   ctrl(1'b1, 1'b1);
                default:   ;
            endcase
            chk($sformatf("tbl%0d_lock", k), bus.o_lock, tbl[k].exp_lock);
            if (tbl[k].chk_cnt) begin
                chk($sformatf("tbl%0d_bits", k), bus.o_bit_cnt, tbl[k].exp_bits);
                chk($sformatf("tbl%0d_errs", k), bus.o_err_cnt, tbl[k].exp_errs);
            end
        end

        // Long idle while locked: nothing may move.
        repeat (50) begin
            @(posedge clk);
            #1;
            check_all(1'b0);
        end

        // Asynchronous reset between edges clears outputs without waiting for a clock.
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_lock",    bus.o_lock,    64'd0);
        chk("rst_bit_cnt", bus.o_bit_cnt, 64'd0);
        chk("rst_err_cnt", bus.o_err_cnt, 64'd0);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < LOCK_BITS; i++) send(gen_next(), 1'b0);
        chk("post_rst_lock", bus.o_lock, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/prbs9_ber_checker.md
Name: prbs9_ber_checker

Overview:
Bit-error-rate checker. Sits directly downstream of the QPSK receiver's symbol decision and bit demapper, in the receive path of the top level.
- Self-synchronises a local PRBS9 (x^9 + x^5 + 1) to the recovered bit stream.
- Declares lock, then counts compared bits and bit errors for readout via the top-level switch/debug path.
- No knowledge of transmitter seed or delay is needed; alignment is derived from the received bits.

Parameters:
CNT_W, 64, width of bit and error counters (saturating)
LOCK_CNT, 32, consecutive correct predictions needed to declare lock
LOCK_WIN, 128, window length in valid bits for loss-of-lock check (LOCK_LOSS_EN only)
LOCK_ERR_MAX, 16, error count within window above which lock is dropped (LOCK_LOSS_EN only)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
i_valid  in  1  one-cycle strobe: i_bit is a new received bit (symbol-rate enable)
i_bit  in  1  received bit
i_clear  in  1  synchronous clear of counters; lock unaffected
i_relock  in  1  synchronous forced return to ST_LOAD
o_lock  out  1  checker locked
o_err  out  1  one-cycle pulse: last compared bit was wrong
o_bit_cnt  out  CNT_W  bits compared while locked
o_err_cnt  out  CNT_W  errors counted while locked

Behaviour:
- Reset: all outputs 0, state ST_LOAD, shift register s[8:0]=0, all internal counters 0.
- Clocking: one clock, async active-high reset. Everything advances only on cycles with i_valid=1, except i_clear and i_relock, which act on any cycle.
- Shift register: s[0] holds the newest bit. Predicted bit is p = s[8] ^ s[4].
- ST_LOAD: shift i_bit into s and count loaded bits. After the 9th valid bit, go to ST_VERIFY with the match counter at 0.
- ST_VERIFY: compare i_bit to p, then shift i_bit into s.
  - Mismatch: go to ST_LOAD with load count 0.
  - Match: match counter +1. When it reaches LOCK_CNT, go to ST_LOCKED.
  - All-zero s (stuck LFSR) on entry or during ST_VERIFY: go to ST_LOAD.
- ST_LOCKED: shift p (not i_bit) into s, so the local LFSR free-runs.
  - bit_cnt +1 per valid bit.
  - err_cnt +1 when i_bit != p.
- Latency: o_lock rises, and counters and o_err update, on the clock edge after the qualifying i_valid cycle. All outputs are registered.
- Saturation: counters hold at all-ones and never wrap.
- Counter scope: counters only increment in ST_LOCKED, and are retained when lock is lost.
- Simultaneous events:
  - i_clear with a counted bit: counters go to 0; the bit is discarded from the count.
  - i_relock has priority over a state transition in the same cycle. It does not clear counters.
  - i_relock and i_clear together: both take effect.
- Idle input: i_valid low for any duration leaves all state frozen.
- Reset mid-operation returns everything to reset values immediately.

Optional Feature:
Macro LOCK_LOSS_EN.
- Defined: in ST_LOCKED, a window counter counts LOCK_WIN valid bits and a window error counter counts errors.
  - At window end, if window errors > LOCK_ERR_MAX, go to ST_LOAD and drop o_lock the next cycle. Otherwise restart the window.
  - Window counters are cleared on entry to ST_LOCKED.
- Not defined: lock is sticky until rst or i_relock. The window logic is absent and LOCK_WIN and LOCK_ERR_MAX are unused.

Decomposition:
- Shared header, qpsk_defs.vh:
  - PRBS9 constants: length 9, tap indices 8 and 4, default seed 9'b110101010.
  - State encodings ST_LOAD=2'd0, ST_VERIFY=2'd1, ST_LOCKED=2'd2.
- One sub-module: prbs9_lfsr.
  - 9-bit register with input mux (external bit or feedback), shift enable and predicted-bit output.
  - Reused by the transmit-side generator.

Test Plan:
- Clean lock: PRBS9 stream from seed 9'b110101010, i_valid every 4th cycle → o_lock rises on the edge after valid bit 41 (9 load + 32 verify). After 1000 further bits: o_bit_cnt=1000, o_err_cnt=0.
- Single errors: once locked, invert bits 100 and 101 after lock → two o_err pulses, o_err_cnt=2, o_lock stays 1. The free-running LFSR must not be corrupted.
- Bad load: flip bit 12 of the stream before lock → return to ST_LOAD; lock is reached later with zero counted errors.
- All-zero input: 500 zero bits → o_lock never asserts, counters stay 0.
- Clear/relock: i_clear during counting → counters 0 next cycle, o_lock=1. i_relock → o_lock=0 next cycle, counters retained. Relock after 41 further bits.
- LOCK_LOSS_EN: switch to an unrelated stream (random, ~50% errors) → o_lock drops at the end of the first window with >16 errors (bit 128 of the window). Without the macro, o_lock stays 1 and err_cnt grows.
